data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16-bit, 64K-word data memory.
- Requester 0 is the CPU load/store path. Requester 1 is the loader/IO path.
- Serialises their read/write requests onto the memory's single read-address, write-address, write-data and active-low write-strobe ports.
- All memory-side signals come from registers, so the level-sensitive write strobe never glitches.
- Each requester sees a request/grant handshake plus a registered read-data return.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request; held high with command stable until the matching gnt is seen.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W  word address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse: the command is being executed this cycle.
- rvalid0, rvalid1  out  1  one-cycle pulse: rdataN holds read data.
- rdata0, rdata1  out  DATA_W  registered read data.
- mem_read_addr  out  ADDR_W  to memory read address.
- mem_write_addr  out  ADDR_W  to memory write address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_write_n  out  1  memory write strobe, active low.
- mem_rdata  in  DATA_W  memory read data; combinational from mem_read_addr.

Behaviour:
- Reset values (asynchronous, effective immediately):
  - state = IDLE.
  - gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0.
  - mem_write_n = 1, mem_read_addr = mem_write_addr = mem_wdata = 0.
  - last_grant = 1, so requester 0 is favoured first.
- FSM states: IDLE and ACCESS.
- IDLE:
  - Sample req0/req1.
  - None asserted: stay in IDLE.
  - Otherwise pick a winner:
    - Only one requester asserted: it wins.
    - Both asserted, FIXED_PRIO = 1: requester 0 wins.
    - Both asserted, FIXED_PRIO = 0: the requester that is not last_grant wins.
  - On the clock edge:
    - Latch winner ID into cur_id and update last_grant.
    - Load mem_read_addr and mem_write_addr with the winner's addr, and mem_wdata with its wdata.
    - Set mem_write_n = ~we of the winner.
    - Go to ACCESS.
- ACCESS (exactly one cycle):
  - gnt[cur_id] = 1. Memory ports hold the latched values.
  - For a write, mem_write_n is 0 for this whole cycle only.
  - On the edge ending ACCESS:
    - mem_write_n returns to 1.
    - If the command was a read, mem_rdata is captured into rdata[cur_id] and rvalid[cur_id] is set for the next cycle.
    - Go to IDLE.
- Timing:
  - Read latency, from the first cycle req is seen in IDLE to rvalid: 2 cycles.
  - Peak throughput: one access per 2 cycles.
- Requests are ignored while in ACCESS. The requester drops req after seeing gnt, so the following IDLE cycle cannot re-grant the same command.
- rdataN holds its value until the next read by that requester. Writes never change rdataN or pulse rvalidN.
- rvalid of a completed read may coincide with the IDLE cycle that arbitrates the next request.
- mem_write_n is never low in IDLE. gnt0 and gnt1 are never high together.
- Reset during ACCESS aborts immediately: mem_write_n forced to 1, no gnt or rvalid afterwards. Whether an aborted write reached memory is undefined.
- Width: no arithmetic. Address and data pass through unmodified. Every address 0x0000 to 0xFFFF is legal.

Decomposition:
- Package data_mem_arb_pkg holds:
  - State typedef {IDLE, ACCESS}.
  - Requester ID constants REQ_CPU = 0 and REQ_LDR = 1.
  - DATA_W and ADDR_W defaults.
- One sub-module, rr_pick2: combinational 2-way pick from req0, req1, last_grant and FIXED_PRIO, returning the winner ID and a valid flag.

Test Plan:
- Write then read, single requester:
  - Stimulus: req0 write addr 0x0010, wdata 0xBEEF; then req0 read addr 0x0010.
  - Response: gnt0 in cycle 2; mem_write_n low only in that cycle; rvalid0 two cycles after the read request with rdata0 = 0xBEEF; req1 outputs stay 0.
- Round-robin contention:
  - Stimulus: req0 and req1 both held continuously with reads of 0x0001 and 0x0002, each requester re-asserting after its gnt.
  - Response: grants alternate gnt0, gnt1, gnt0, gnt1 after reset, with one grant every 2 cycles.
- Fixed priority:
  - Stimulus: FIXED_PRIO = 1, both requesting.
  - Response: gnt0 every time; gnt1 only in cycles where req0 = 0.
- Address extremes:
  - Stimulus: req1 writes 0xFFFF to address 0xFFFF and 0x1234 to address 0x0000, then reads both.
  - Response: rdata1 = 0xFFFF, then 0x1234.
- Reset mid-write:
  - Stimulus: assert rst in the middle of the ACCESS cycle of a write.
  - Response: mem_write_n goes to 1 without waiting for a clock edge; gnt0/1 = 0 and rvalid0/1 = 0 on the next edge; after release, the first contended grant goes to requester 0.
- Request held only until grant:
  - Stimulus: req0 read, deasserted one cycle after gnt0.
  - Response: exactly one gnt0 pulse and one rvalid0 pulse; no duplicate access; mem_write_n stays 1 throughout.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the two-requester data memory arbiter.
// No logic; latency and backpressure are defined by the modules that use it.
package data_mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way winner select; zero latency.
// No backpressure of its own: the winner only matters when the caller is ready to load it.
module rr_pick2
  import data_mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic win_id,
  output logic win_vld
);

  always_comb begin
    win_vld = req0 | req1;
    win_id  = REQ_CPU;
    if (req0 && req1) begin
      // On a tie, round-robin hands the slot to whoever was not served last.
      win_id = (FIXED_PRIO != 0) ? REQ_CPU : ~last_grant;
    end else if (req1) begin
      win_id = REQ_LDR;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: serialises CPU and loader accesses onto one data memory port set.
// Read data 2 cycles after req is seen; req is held until gnt, one access every 2 cycles.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_n,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              cur_id;
  logic              cur_we;
  logic              load;
  logic              capture;
  logic              win_id;
  logic              win_vld;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_grant(last_grant),
    .win_id    (win_id),
    .win_vld   (win_vld)
  );

  assign win_we    = (win_id == REQ_LDR) ? we1    : we0;
  assign win_addr  = (win_id == REQ_LDR) ? addr1  : addr0;
  assign win_wdata = (win_id == REQ_LDR) ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = ACCESS;
          load      = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
        capture   = ~cur_we;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every memory-side and requester-side output is a flop so the strobe is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_read_addr  <= '0;
      mem_write_addr <= '0;
      mem_wdata      <= '0;
      mem_write_n    <= 1'b1;
      last_grant     <= REQ_LDR;
      cur_id         <= REQ_CPU;
      cur_we         <= 1'b0;
    end else begin
      gnt0        <= load && (win_id == REQ_CPU);
      gnt1        <= load && (win_id == REQ_LDR);
      mem_write_n <= ~(load && win_we);
      rvalid0     <= capture && (cur_id == REQ_CPU);
      rvalid1     <= capture && (cur_id == REQ_LDR);
      if (load) begin
        cur_id         <= win_id;
        cur_we         <= win_we;
        last_grant     <= win_id;
        mem_read_addr  <= win_addr;
        mem_write_addr <= win_addr;
        mem_wdata      <= win_wdata;
      end
      if (capture && (cur_id == REQ_CPU)) begin
        rdata0 <= mem_rdata;
      end
      if (capture && (cur_id == REQ_LDR)) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a round-robin and a fixed-priority instance, each with its own memory.
// Scoreboard of expected read data per requester plus a monitor predicting every grant.
module tb_data_mem_arbiter;

  localparam int BUDGET = 200;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gap;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Requester index k = 2*dut + requester; dut 0 is round-robin, dut 1 fixed priority.
  logic        req    [4];
  logic        we_s   [4];
  logic [15:0] addr_s [4];
  logic [15:0] wdata_s[4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [15:0] rdata  [4];
  logic [15:0] mra [2];
  logic [15:0] mwa [2];
  logic [15:0] mwd [2];
  logic [15:0] mrd [2];
  logic        mwn [2];

  int total = 0;
  int bad   = 0;

  cmd_t        cq    [4][$];
  logic [15:0] exp_q [4][$];
  logic [15:0] mem_w   [int];
  logic [15:0] ref_mem [int];

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we_s[0]), .we1(we_s[1]),
    .addr0(addr_s[0]), .addr1(addr_s[1]), .wdata0(wdata_s[0]), .wdata1(wdata_s[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
    .rdata0(rdata[0]), .rdata1(rdata[1]),
    .mem_read_addr(mra[0]), .mem_write_addr(mwa[0]), .mem_wdata(mwd[0]),
    .mem_write_n(mwn[0]), .mem_rdata(mrd[0])
  );

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req[2]), .req1(req[3]), .we0(we_s[2]), .we1(we_s[3]),
    .addr0(addr_s[2]), .addr1(addr_s[3]), .wdata0(wdata_s[2]), .wdata1(wdata_s[3]),
    .gnt0(gnt[2]), .gnt1(gnt[3]), .rvalid0(rvalid[2]), .rvalid1(rvalid[3]),
    .rdata0(rdata[2]), .rdata1(rdata[3]),
    .mem_read_addr(mra[1]), .mem_write_addr(mwa[1]), .mem_wdata(mwd[1]),
    .mem_write_n(mwn[1]), .mem_rdata(mrd[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int d, input logic [15:0] a);
    return a ^ ((d == 0) ? 16'h5A5A : 16'hC3C3);
  endfunction

  function automatic logic [15:0] ref_rd(input int d, input logic [15:0] a);
    int key;
    key = d * 65536 + int'(a);
    if (ref_mem.exists(key)) return ref_mem[key];
    return init_val(d, a);
  endfunction

  // Level-sensitive memories: the strobe is low for whole cycles, so mid-cycle sampling suffices.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!mwn[d]) mem_w[d * 65536 + int'(mwa[d])] = mwd[d];
      if (mem_w.exists(d * 65536 + int'(mra[d]))) mrd[d] = mem_w[d * 65536 + int'(mra[d])];
      else mrd[d] = init_val(d, mra[d]);
    end
  end

  task automatic push(input int k, input logic we, input logic [15:0] a,
                      input logic [15:0] wd, input int gap);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd; c.gap = gap;
    cq[k].push_back(c);
  endtask

  task automatic drive(input int k);
    cmd_t c;
    int   n;
    req[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
    forever begin
      if (cq[k].size() == 0) begin
        req[k] = 1'b0;
        @(posedge clk); #1;
      end else begin
        c = cq[k].pop_front();
        for (int i = 0; i < c.gap; i++) begin
          req[k] = 1'b0;
          @(posedge clk); #1;
        end
        we_s[k] = c.we; addr_s[k] = c.addr; wdata_s[k] = c.wdata; req[k] = 1'b1;
        if (c.we) ref_mem[(k / 2) * 65536 + int'(c.addr)] = c.wdata;
        else exp_q[k].push_back(ref_rd(k / 2, c.addr));
        n = 0;
        do begin
          @(posedge clk); #1; n++;
        end while (!gnt[k] && n < BUDGET);
        chk($sformatf("gnt_seen k%0d", k), 32'(gnt[k]), 32'd1);
      end
    end
  endtask

  logic        last_w [2];
  logic        exp_gv [2];
  int          exp_gid[2];
  logic        exp_gwe[2];
  logic [15:0] exp_ga [2];
  logic [15:0] exp_gd [2];
  logic        exp_rv [4];
  logic [15:0] last_rd[4];

  task automatic mon(input int d);
    int   k0;
    int   gid;
    logic g0, g1;
    logic rvn[2];
    k0 = 2 * d;
    g0 = gnt[k0];
    g1 = gnt[k0 + 1];
    if (rst) begin
      last_w[d] = 1'b1; exp_gv[d] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        exp_rv[k0 + r] = 1'b0; last_rd[k0 + r] = '0;
      end
      return;
    end
    chk($sformatf("gnt_exclusive d%0d", d), 32'(g0 & g1), 32'd0);
    rvn[0] = 1'b0; rvn[1] = 1'b0;
    if (exp_gv[d]) begin
      chk($sformatf("gnt_winner d%0d", d), 32'({g1, g0}), (exp_gid[d] == 0) ? 32'd1 : 32'd2);
      chk($sformatf("mem_write_n_access d%0d", d), 32'(mwn[d]), 32'(!exp_gwe[d]));
      chk($sformatf("mem_read_addr d%0d", d), 32'(mra[d]), 32'(exp_ga[d]));
      chk($sformatf("mem_write_addr d%0d", d), 32'(mwa[d]), 32'(exp_ga[d]));
      if (exp_gwe[d]) chk($sformatf("mem_wdata d%0d", d), 32'(mwd[d]), 32'(exp_gd[d]));
      else rvn[exp_gid[d]] = 1'b1;
      last_w[d] = (exp_gid[d] == 1);
    end else begin
      chk($sformatf("gnt_unexpected d%0d", d), 32'({g1, g0}), 32'd0);
      chk($sformatf("mem_write_n_idle d%0d", d), 32'(mwn[d]), 32'd1);
    end
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("rvalid k%0d", k0 + r), 32'(rvalid[k0 + r]), 32'(exp_rv[k0 + r]));
      if (rvalid[k0 + r] && exp_q[k0 + r].size() > 0) last_rd[k0 + r] = exp_q[k0 + r].pop_front();
      chk($sformatf("rdata k%0d", k0 + r), 32'(rdata[k0 + r]), 32'(last_rd[k0 + r]));
      exp_rv[k0 + r] = rvn[r];
    end
    // A request seen while no grant is showing must be served on the very next cycle.
    if (!g0 && !g1 && (req[k0] || req[k0 + 1])) begin
      if (req[k0] && req[k0 + 1]) gid = (d == 1) ? 0 : (last_w[d] ? 0 : 1);
      else gid = req[k0] ? 0 : 1;
      exp_gv[d]  = 1'b1;
      exp_gid[d] = gid;
      exp_gwe[d] = we_s[k0 + gid];
      exp_ga[d]  = addr_s[k0 + gid];
      exp_gd[d]  = wdata_s[k0 + gid];
    end else begin
      exp_gv[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    fork
      drive(0);
      drive(1);
      drive(2);
      drive(3);
    join_none
  end

  task automatic wait_idle();
    int n;
    bit busy;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
      busy = 1'b0;
      for (int k = 0; k < 4; k++)
        if (cq[k].size() != 0 || req[k] || exp_q[k].size() != 0) busy = 1'b1;
    end while (busy && n < 4000);
    chk("idle_reached", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_gnt k%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("reset_rvalid k%0d", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("reset_rdata k%0d", k), 32'(rdata[k]), 32'd0);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_mem_write_n d%0d", d), 32'(mwn[d]), 32'd1);
      chk($sformatf("reset_mem_read_addr d%0d", d), 32'(mra[d]), 32'd0);
      chk($sformatf("reset_mem_write_addr d%0d", d), 32'(mwa[d]), 32'd0);
      chk($sformatf("reset_mem_wdata d%0d", d), 32'(mwd[d]), 32'd0);
    end
    @(posedge clk); #3;
    rst = 1'b0;

    // Write then read back on the CPU port alone.
    @(negedge clk);
    push(0, 1'b1, 16'h0010, 16'hBEEF, 0);
    push(0, 1'b0, 16'h0010, 16'h0000, 0);
    wait_idle();
    chk("wr_rd_rdata0", 32'(rdata[0]), 32'h0000_BEEF);
    chk("wr_rd_rdata1_untouched", 32'(rdata[1]), 32'd0);

    // Continuous contention on the round-robin instance.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b0, 16'h0001, 16'h0000, 0);
      push(1, 1'b0, 16'h0002, 16'h0000, 0);
    end
    wait_idle();
    chk("rr_rdata0", 32'(rdata[0]), 32'(init_val(0, 16'h0001)));
    chk("rr_rdata1", 32'(rdata[1]), 32'(init_val(0, 16'h0002)));

    // Continuous contention on the fixed-priority instance.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push(2, 1'b0, 16'h0003, 16'h0000, 0);
      push(3, 1'b0, 16'h0004, 16'h0000, 0);
    end
    wait_idle();

    // Address extremes on the loader port.
    @(negedge clk);
    push(1, 1'b1, 16'hFFFF, 16'hFFFF, 0);
    push(1, 1'b1, 16'h0000, 16'h1234, 0);
    push(1, 1'b0, 16'hFFFF, 16'h0000, 0);
    wait_idle();
    chk("extreme_rdata_ffff", 32'(rdata[1]), 32'h0000_FFFF);
    @(negedge clk);
    push(1, 1'b0, 16'h0000, 16'h0000, 0);
    wait_idle();
    chk("extreme_rdata_0000", 32'(rdata[1]), 32'h0000_1234);

    // Random traffic; each requester owns a private write region so ordering stays per-requester.
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      for (int k = 0; k < 4; k++) begin
        push(k, 1'($urandom_range(0, 1)),
             (k % 2 == 0) ? 16'(16'h0010 + $urandom_range(0, 15)) : 16'(16'h8000 + $urandom_range(0, 15)),
             16'($urandom), $urandom_range(0, 2));
      end
    end
    wait_idle();

    // Reset in the middle of a write's access cycle.
    @(negedge clk);
    push(0, 1'b1, 16'h0020, 16'hA5A5, 0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!gnt[0] && n < BUDGET);
    chk("rst_test_gnt0", 32'(gnt[0]), 32'd1);
    chk("rst_test_strobe_low", 32'(mwn[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_write_n", 32'(mwn[0]), 32'd1);
    @(posedge clk); #1;
    chk("rst_gnt0", 32'(gnt[0]), 32'd0);
    chk("rst_gnt1", 32'(gnt[1]), 32'd0);
    chk("rst_rvalid0", 32'(rvalid[0]), 32'd0);
    chk("rst_rvalid1", 32'(rvalid[1]), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    push(0, 1'b0, 16'h0011, 16'h0000, 0);
    push(1, 1'b0, 16'h8001, 16'h0000, 0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!gnt[0] && !gnt[1] && n < BUDGET);
    chk("post_rst_first_gnt", 32'({gnt[1], gnt[0]}), 32'd1);
    wait_idle();
    chk("post_rst_rdata0", 32'(rdata[0]), 32'(ref_rd(0, 16'h0011)));
    chk("post_rst_rdata1", 32'(rdata[1]), 32'(ref_rd(0, 16'h8001)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
